// File: rtl/program_loader_pkg.sv
// Shared definitions for the program download path: loader states, word width and the
// end-of-program marker, also used by the debug unit.
package program_loader_pkg;

    localparam int unsigned WORD_W = 32;
    localparam logic [WORD_W-1:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        StIdle,
        StRecv,
        StWrite,
        StDone,
        StError
    } loader_state_e;

endpackage

// File: rtl/program_loader_byte_packer.sv
// Packs received bytes MSB first into one instruction word and flags the byte that
// completes the word.
module program_loader_byte_packer
    import program_loader_pkg::*;
#(
    parameter int unsigned DATA_W         = WORD_W,
    parameter int unsigned BYTES_PER_WORD = 4,
    localparam int unsigned CNT_W         = $clog2(BYTES_PER_WORD + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [7:0]        rx_data,
    output logic [DATA_W-1:0] word,
    output logic [CNT_W-1:0]  byte_cnt,
    output logic              word_ready
);

    logic [DATA_W-1:0] word_q;
    logic [CNT_W-1:0]  cnt_q;

    assign word_ready = shift_en && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));
    assign word       = word_q;
    assign byte_cnt   = cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (shift_en) begin
            word_q <= {word_q[DATA_W-9:0], rx_data};
            cnt_q  <= word_ready ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Download loader: assembles UART bytes into instructions and writes them to instruction
// memory at consecutive word addresses until the HALT word, overflow or a byte timeout.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned       DATA_W         = WORD_W,
    parameter int unsigned       BYTES_PER_WORD = 4,
    parameter int unsigned       MAX_WORDS      = 1024,
    parameter logic [DATA_W-1:0] HALT_WORD      = DEFAULT_HALT_WORD,
    parameter int unsigned       TIMEOUT        = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              load_program,
    output logic              wr_instruction,
    output logic [31:0]       instr_addr,
    output logic [DATA_W-1:0] instr_data,
    output logic [31:0]       word_count,
    output logic              load_done,
    output logic              load_error
);

    localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD + 1);

    loader_state_e    state_q, state_d;
    logic [31:0]      addr_q, count_q, timer_q;
    logic [CNT_W-1:0] byte_cnt;
    logic             word_ready, shift_en, clear_packer;
    logic             restart, timed_out, is_halt, at_last_addr;

    assign restart      = start && (state_q inside {StIdle, StDone, StError});
    assign timed_out    = (state_q == StRecv) && (byte_cnt != '0) && (timer_q == TIMEOUT);
    assign is_halt      = (instr_data == HALT_WORD);
    assign at_last_addr = (addr_q == 32'(MAX_WORDS - 1));

    // A byte in the WRITE cycle belongs to the next word unless the loader is stopping.
    always_comb begin
        shift_en     = 1'b0;
        clear_packer = restart || timed_out;
        if (rx_valid) begin
            if (state_q == StRecv) begin
                shift_en = !timed_out;
            end else if (state_q == StWrite) begin
                shift_en = !is_halt && !at_last_addr;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone, StError: if (restart) state_d = StRecv;
            StRecv: begin
                if (timed_out) begin
                    state_d = StError;
                end else if (word_ready) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (is_halt) begin
                    state_d = StDone;
                end else if (at_last_addr) begin
                    state_d = StError;
                end else begin
                    state_d = StRecv;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (restart) begin
                addr_q  <= '0;
                count_q <= '0;
            end else if (state_q == StWrite) begin
                addr_q  <= addr_q + 1'b1;
                count_q <= count_q + 1'b1;
            end
        end
    end

    // Counts idle cycles only while a word is partially assembled.
    always_ff @(posedge clk) begin
        if (rst || state_q != StRecv || rx_valid || byte_cnt == '0) begin
            timer_q <= '0;
        end else if (timer_q != TIMEOUT) begin
            timer_q <= timer_q + 1'b1;
        end
    end

    program_loader_byte_packer #(
        .DATA_W        (DATA_W),
        .BYTES_PER_WORD(BYTES_PER_WORD)
    ) u_byte_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear_packer),
        .shift_en  (shift_en),
        .rx_data   (rx_data),
        .word      (instr_data),
        .byte_cnt  (byte_cnt),
        .word_ready(word_ready)
    );

    assign load_program   = (state_q == StRecv) || (state_q == StWrite);
    assign wr_instruction = (state_q == StWrite);
    assign load_done      = (state_q == StDone);
    assign load_error     = (state_q == StError);
    assign instr_addr     = addr_q;
    assign word_count     = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a small memory depth and short byte timeout.
module tb_program_loader;

    localparam int unsigned TIMEOUT   = 20;
    localparam int unsigned MAX_WORDS = 4;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        load_program;
    logic        wr_instruction;
    logic [31:0] instr_addr;
    logic [31:0] instr_data;
    logic [31:0] word_count;
    logic        load_done;
    logic        load_error;

    int n_vec = 0;
    int n_bad = 0;
    int wr_count = 0;
    int base;
    logic [31:0] wr_addrs [64];
    logic [31:0] wr_datas [64];

    program_loader #(
        .DATA_W        (32),
        .BYTES_PER_WORD(4),
        .MAX_WORDS     (MAX_WORDS),
        .HALT_WORD     (32'hFFFF_FFFF),
        .TIMEOUT       (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .load_program  (load_program),
        .wr_instruction(wr_instruction),
        .instr_addr    (instr_addr),
        .instr_data    (instr_data),
        .word_count    (word_count),
        .load_done     (load_done),
        .load_error    (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write log, sampled just after each active edge.
    always @(posedge clk) begin
        #1;
        if (wr_instruction === 1'b1 && wr_count < 64) begin
            wr_addrs[wr_count] = instr_addr;
            wr_datas[wr_count] = instr_data;
            wr_count++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_wr(input string tag, input int idx, input logic [31:0] addr,
                            input logic [31:0] data);
        check({tag, "_addr"}, (idx < 64) ? wr_addrs[idx] : 32'hDEAD_0000, addr);
        check({tag, "_data"}, (idx < 64) ? wr_datas[idx] : 32'hDEAD_0000, data);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_load_program"}, 32'(load_program), 32'd0);
        check({tag, "_wr"}, 32'(wr_instruction), 32'd0);
        check({tag, "_addr"}, instr_addr, 32'd0);
        check({tag, "_data"}, instr_data, 32'd0);
        check({tag, "_count"}, word_count, 32'd0);
        check({tag, "_done"}, 32'(load_done), 32'd0);
        check({tag, "_error"}, 32'(load_error), 32'd0);
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single word 0x00000001.
        pulse_start();
        check("t1_load_program", 32'(load_program), 32'd1);
        base = wr_count;
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        check("t1_wr_strobe", 32'(wr_instruction), 32'd1);
        check("t1_addr_in_write", instr_addr, 32'd0);
        check("t1_data_in_write", instr_data, 32'h0000_0001);
        @(negedge clk);
        check("t1_wr_count", 32'(wr_count - base), 32'd1);
        check_wr("t1_w0", base, 32'd0, 32'h0000_0001);
        check("t1_word_count", word_count, 32'd1);
        check("t1_wr_deasserted", 32'(wr_instruction), 32'd0);

        // Two words ending in HALT, back to back; start is ignored in RECV so reset first.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pulse_start();
        base = wr_count;
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
        check("t2_halt_addr", instr_addr, 32'd1);
        check("t2_halt_data", instr_data, 32'hFFFF_FFFF);
        @(negedge clk);
        check("t2_wr_count", 32'(wr_count - base), 32'd2);
        check_wr("t2_w0", base, 32'd0, 32'h1234_5678);
        check_wr("t2_w1", base + 1, 32'd1, 32'hFFFF_FFFF);
        check("t2_load_done", 32'(load_done), 32'd1);
        check("t2_load_program", 32'(load_program), 32'd0);
        check("t2_word_count", word_count, 32'd2);
        send_byte(8'h99);
        @(negedge clk);
        check("t2_byte_in_done_dropped", 32'(wr_count - base), 32'd2);

        // Byte arriving during WRITE starts the next word.
        pulse_start();
        check("t3_done_cleared", 32'(load_done), 32'd0);
        check("t3_count_cleared", word_count, 32'd0);
        base = wr_count;
        send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
        send_byte(8'h5E); send_byte(8'h6F); send_byte(8'h70); send_byte(8'h81);
        @(negedge clk);
        check("t3_wr_count", 32'(wr_count - base), 32'd2);
        check_wr("t3_w0", base, 32'd0, 32'hA1B2_C3D4);
        check_wr("t3_w1", base + 1, 32'd1, 32'h5E6F_7081);

        // Timeout on a partial word.
        base = wr_count;
        send_byte(8'h33); send_byte(8'h44);
        repeat (TIMEOUT - 1) @(negedge clk);
        check("t4_no_early_error", 32'(load_error), 32'd0);
        check("t4_still_loading", 32'(load_program), 32'd1);
        for (int i = 0; i < 10 && load_error !== 1'b1; i++) @(negedge clk);
        check("t4_load_error", 32'(load_error), 32'd1);
        check("t4_no_write", 32'(wr_count - base), 32'd0);
        check("t4_partial_lost", instr_data, 32'd0);
        check("t4_word_count", word_count, 32'd2);

        // Overflow at MAX_WORDS.
        pulse_start();
        check("t5_error_cleared", 32'(load_error), 32'd0);
        check("t5_addr_cleared", instr_addr, 32'd0);
        base = wr_count;
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        @(negedge clk);
        check("t5_load_error", 32'(load_error), 32'd1);
        check("t5_word_count", word_count, 32'd4);
        check("t5_load_program", 32'(load_program), 32'd0);
        for (int i = 0; i < 4; i++) send_byte(8'hAA);
        repeat (2) @(negedge clk);
        check("t5_wr_count", 32'(wr_count - base), 32'd4);
        check_wr("t5_w0", base, 32'd0, 32'h0001_0203);
        check_wr("t5_w1", base + 1, 32'd1, 32'h0405_0607);
        check_wr("t5_w2", base + 2, 32'd2, 32'h0809_0A0B);
        check_wr("t5_w3", base + 3, 32'd3, 32'h0C0D_0E0F);

        // Reset mid-word, then restart from address 0.
        pulse_start();
        base = wr_count;
        for (int i = 0; i < 8; i++) send_byte(8'h11 + 8'(i));
        send_byte(8'h21); send_byte(8'h22);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("t6_rst");
        rst = 1'b0;
        check("t6_wr_count", 32'(wr_count - base), 32'd2);
        check_wr("t6_w1", base + 1, 32'd1, 32'h1516_1718);
        pulse_start();
        base = wr_count;
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        @(negedge clk);
        check("t6_restart_wr_count", 32'(wr_count - base), 32'd1);
        check_wr("t6_restart", base, 32'd0, 32'hDEAD_BEEF);
        check("t6_word_count", word_count, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
